// File: rtl/operand_wait_queue_pkg.sv
// Shared types for the operand wait queue: decomposed-instruction entry layout and widths.
package operand_wait_queue_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CTRL_W = 12;
  localparam int unsigned REG_W  = 5;

  // Entry word, MSB first: {ctrl, rs2_vt, s2_valid, rs1_vt, s1_valid, rd} = 2*XLEN+19 bits
  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   rs2_vt;
    logic              s2_valid;
    logic [XLEN-1:0]   rs1_vt;
    logic              s1_valid;
    logic [REG_W-1:0]  rd;
  } inst_t;

  // An entry may leave the queue only when both operands are resolved
  function automatic logic inst_resolved(inst_t i);
    return i.s1_valid & i.s2_valid;
  endfunction

endpackage

// File: rtl/operand_wait_queue_if.sv
// Decode-side, forwarding-bus and dispatch-side signals of the operand wait queue.
interface operand_wait_queue_if #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned FWD_PORTS = 2
);
  import operand_wait_queue_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                        flush;
  logic                        in_valid;
  logic                        in_ready;
  inst_t                       in_inst;
  logic [REG_W-1:0]            in_rs1;
  logic [REG_W-1:0]            in_rs2;
  logic [FWD_PORTS-1:0]        fwd_valid;
  logic [REG_W*FWD_PORTS-1:0]  fwd_addr;
  logic [XLEN*FWD_PORTS-1:0]   fwd_data;
  logic                        out_valid;
  logic                        out_ready;
  inst_t                       out_inst;
  logic [CNT_W-1:0]            count;

  modport master (
    output flush, in_valid, in_inst, in_rs1, in_rs2,
    output fwd_valid, fwd_addr, fwd_data, out_ready,
    input  in_ready, out_valid, out_inst, count
  );

  modport slave (
    input  flush, in_valid, in_inst, in_rs1, in_rs2,
    input  fwd_valid, fwd_addr, fwd_data, out_ready,
    output in_ready, out_valid, out_inst, count
  );

endinterface

// File: rtl/operand_wait_queue_snoop.sv
// One operand slot: resolves a pending operand from the forwarding buses (lowest port wins).
module operand_wait_queue_snoop
  import operand_wait_queue_pkg::*;
#(
  parameter int unsigned FWD_PORTS = 2
) (
  input  logic                       valid,
  input  logic [XLEN-1:0]            vt,
  input  logic [REG_W-1:0]           tag,
  input  logic [FWD_PORTS-1:0]       fwd_valid,
  input  logic [REG_W*FWD_PORTS-1:0] fwd_addr,
  input  logic [XLEN*FWD_PORTS-1:0]  fwd_data,
  output logic                       valid_c,
  output logic [XLEN-1:0]            vt_c
);

  logic hit;

  // Next {valid,vt}: keep resolved values, x0 reads as zero, else first matching port
  always_comb begin
    hit     = 1'b0;
    valid_c = valid;
    vt_c    = vt;
    if (!valid) begin
      if (tag == '0) begin
        valid_c = 1'b1;
        vt_c    = '0;
      end else begin
        for (int p = 0; p < FWD_PORTS; p++) begin
          if (!hit && fwd_valid[p] && (fwd_addr[REG_W*p +: REG_W] == tag)) begin
            hit     = 1'b1;
            valid_c = 1'b1;
            vt_c    = fwd_data[XLEN*p +: XLEN];
          end
        end
      end
    end
  end

endmodule

// File: rtl/operand_wait_queue.sv
// In-order operand wait queue between decode and dispatch with multi-port forwarding snoop.
module operand_wait_queue
  import operand_wait_queue_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned FWD_PORTS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  operand_wait_queue_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  inst_t            mem_q  [DEPTH];
  inst_t            mem_n  [DEPTH];
  logic [REG_W-1:0] tag1_q [DEPTH];
  logic [REG_W-1:0] tag1_n [DEPTH];
  logic [REG_W-1:0] tag2_q [DEPTH];
  logic [REG_W-1:0] tag2_n [DEPTH];
  logic [DEPTH-1:0] occ_q, occ_n;
  logic [PTR_W-1:0] rd_q, rd_n, wr_q, wr_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             ov_q, ov_n, ir_q, ir_n;
  inst_t            oi_q, oi_n;
  inst_t            head;
  logic             enq, deq;

  logic [DEPTH-1:0] s1v_c, s2v_c;
  logic [XLEN-1:0]  s1vt_c [DEPTH];
  logic [XLEN-1:0]  s2vt_c [DEPTH];
  logic             b1v_c, b2v_c;
  logic [XLEN-1:0]  b1vt_c, b2vt_c;

  // Per-entry operand snoopers
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    operand_wait_queue_snoop #(.FWD_PORTS(FWD_PORTS)) u_s1 (
      .valid(mem_q[g].s1_valid), .vt(mem_q[g].rs1_vt), .tag(tag1_q[g]),
      .fwd_valid(bus.fwd_valid), .fwd_addr(bus.fwd_addr), .fwd_data(bus.fwd_data),
      .valid_c(s1v_c[g]), .vt_c(s1vt_c[g])
    );
    operand_wait_queue_snoop #(.FWD_PORTS(FWD_PORTS)) u_s2 (
      .valid(mem_q[g].s2_valid), .vt(mem_q[g].rs2_vt), .tag(tag2_q[g]),
      .fwd_valid(bus.fwd_valid), .fwd_addr(bus.fwd_addr), .fwd_data(bus.fwd_data),
      .valid_c(s2v_c[g]), .vt_c(s2vt_c[g])
    );
  end

  // Enqueue bypass: incoming operands see the same-cycle broadcasts
  operand_wait_queue_snoop #(.FWD_PORTS(FWD_PORTS)) u_byp1 (
    .valid(bus.in_inst.s1_valid), .vt(bus.in_inst.rs1_vt), .tag(bus.in_rs1),
    .fwd_valid(bus.fwd_valid), .fwd_addr(bus.fwd_addr), .fwd_data(bus.fwd_data),
    .valid_c(b1v_c), .vt_c(b1vt_c)
  );
  operand_wait_queue_snoop #(.FWD_PORTS(FWD_PORTS)) u_byp2 (
    .valid(bus.in_inst.s2_valid), .vt(bus.in_inst.rs2_vt), .tag(bus.in_rs2),
    .fwd_valid(bus.fwd_valid), .fwd_addr(bus.fwd_addr), .fwd_data(bus.fwd_data),
    .valid_c(b2v_c), .vt_c(b2vt_c)
  );

  // Next queue state; outputs are precomputed from the next head so they can be registered
  always_comb begin
    mem_n  = mem_q;
    tag1_n = tag1_q;
    tag2_n = tag2_q;
    occ_n  = occ_q;
    rd_n   = rd_q;
    wr_n   = wr_q;
    deq    = ov_q & bus.out_ready;
    enq    = bus.in_valid & ir_q;

    for (int i = 0; i < DEPTH; i++) begin
      if (occ_q[i]) begin
        mem_n[i].s1_valid = s1v_c[i];
        mem_n[i].rs1_vt   = s1vt_c[i];
        mem_n[i].s2_valid = s2v_c[i];
        mem_n[i].rs2_vt   = s2vt_c[i];
      end
    end

    if (deq) begin
      occ_n[rd_q] = 1'b0;
      rd_n        = rd_q + PTR_W'(1);
    end

    if (enq) begin
      mem_n[wr_q]          = bus.in_inst;
      mem_n[wr_q].s1_valid = b1v_c;
      mem_n[wr_q].rs1_vt   = b1vt_c;
      mem_n[wr_q].s2_valid = b2v_c;
      mem_n[wr_q].rs2_vt   = b2vt_c;
      tag1_n[wr_q]         = bus.in_rs1;
      tag2_n[wr_q]         = bus.in_rs2;
      occ_n[wr_q]          = 1'b1;
      wr_n                 = wr_q + PTR_W'(1);
    end

    cnt_n = cnt_q + CNT_W'(enq) - CNT_W'(deq);

    if (bus.flush) begin
      occ_n = '0;
      rd_n  = '0;
      wr_n  = '0;
      cnt_n = '0;
    end

    head = mem_n[rd_n];
    ov_n = occ_n[rd_n] & inst_resolved(head);
    oi_n = ov_n ? head : '0;
    ir_n = (cnt_n < CNT_W'(DEPTH));
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i]  <= '0;
        tag1_q[i] <= '0;
        tag2_q[i] <= '0;
      end
      occ_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      ov_q  <= 1'b0;
      oi_q  <= '0;
      ir_q  <= 1'b1;
    end else begin
      mem_q  <= mem_n;
      tag1_q <= tag1_n;
      tag2_q <= tag2_n;
      occ_q  <= occ_n;
      rd_q   <= rd_n;
      wr_q   <= wr_n;
      cnt_q  <= cnt_n;
      ov_q   <= ov_n;
      oi_q   <= oi_n;
      ir_q   <= ir_n;
    end
  end

  assign bus.in_ready  = ir_q;
  assign bus.out_valid = ov_q;
  assign bus.out_inst  = oi_q;
  assign bus.count     = cnt_q;

endmodule

// File: tb/tb_operand_wait_queue.sv
// Bench for operand_wait_queue: directed vector table, corner sequences, random vs queue model.
module tb_operand_wait_queue;
  import operand_wait_queue_pkg::*;

  localparam int DEPTH     = 4;
  localparam int FWD_PORTS = 2;
  localparam int CNT_W     = 3;

  typedef logic [87:0] obs_t;  // {in_ready, out_valid, count[2:0], out_inst[82:0]}

  typedef struct {
    inst_t      w;
    logic [4:0] t1;
    logic [4:0] t2;
  } ment_t;

  typedef struct {
    logic       flush;
    logic       in_valid;
    inst_t      inst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [1:0] fv;
    logic [9:0] fa;
    logic [63:0] fd;
    logic       ordy;
    obs_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        flush_i, in_valid_i, ordy_i;
  inst_t       in_inst_i;
  logic [4:0]  rs1_i, rs2_i;
  logic [1:0]  fv_i;
  logic [9:0]  fa_i;
  logic [63:0] fd_i;

  operand_wait_queue_if #(.DEPTH(DEPTH), .FWD_PORTS(FWD_PORTS)) bus ();

  assign bus.flush     = flush_i;
  assign bus.in_valid  = in_valid_i;
  assign bus.in_inst   = in_inst_i;
  assign bus.in_rs1    = rs1_i;
  assign bus.in_rs2    = rs2_i;
  assign bus.fwd_valid = fv_i;
  assign bus.fwd_addr  = fa_i;
  assign bus.fwd_data  = fd_i;
  assign bus.out_ready = ordy_i;

  operand_wait_queue #(.DEPTH(DEPTH), .FWD_PORTS(FWD_PORTS)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  ment_t mq[$];
  vec_t  vecs[$];
  int    checks = 0;
  int    failures = 0;

  function automatic inst_t mk(logic [11:0] c, logic [31:0] v2, logic s2,
                               logic [31:0] v1, logic s1, logic [4:0] rd);
    inst_t r;
    r.ctrl = c; r.rs2_vt = v2; r.s2_valid = s2;
    r.rs1_vt = v1; r.s1_valid = s1; r.rd = rd;
    return r;
  endfunction

  function automatic obs_t ob(logic ir, logic ov, int cnt, inst_t w);
    return {ir, ov, CNT_W'(cnt), w};
  endfunction

  function automatic obs_t observe();
    return {bus.in_ready, bus.out_valid, bus.count, bus.out_inst};
  endfunction

  // Reference: expected outputs straight from the queue contents
  function automatic obs_t model_obs();
    inst_t h = '0;
    logic  v = 1'b0;
    if (mq.size() > 0 && mq[0].w.s1_valid && mq[0].w.s2_valid) begin
      v = 1'b1;
      h = mq[0].w;
    end
    return {(mq.size() < DEPTH), v, CNT_W'(mq.size()), h};
  endfunction

  // Operand resolution rule: valid stays, x0 is zero, else lowest matching port
  function automatic logic [32:0] res_op(logic v, logic [31:0] d, logic [4:0] tag);
    logic [32:0] r = {v, d};
    if (!v) begin
      if (tag == 5'd0) r = {1'b1, 32'd0};
      else
        for (int p = FWD_PORTS - 1; p >= 0; p--)
          if (fv_i[p] && fa_i[5*p +: 5] == tag) r = {1'b1, fd_i[32*p +: 32]};
    end
    return r;
  endfunction

  function automatic ment_t res_ent(ment_t e);
    logic [32:0] r;
    r = res_op(e.w.s1_valid, e.w.rs1_vt, e.t1);
    e.w.s1_valid = r[32]; e.w.rs1_vt = r[31:0];
    r = res_op(e.w.s2_valid, e.w.rs2_vt, e.t2);
    e.w.s2_valid = r[32]; e.w.rs2_vt = r[31:0];
    return e;
  endfunction

  // Advance the model by one clock edge using the currently driven inputs
  task automatic model_step();
    obs_t  cur;
    logic  deq, enq;
    ment_t e;
    cur = model_obs();
    deq = cur[86] & ordy_i;
    enq = in_valid_i & (mq.size() < DEPTH);
    if (flush_i) begin
      mq.delete();
      return;
    end
    foreach (mq[i]) mq[i] = res_ent(mq[i]);
    if (deq) void'(mq.pop_front());
    if (enq) begin
      e.w = in_inst_i; e.t1 = rs1_i; e.t2 = rs2_i;
      mq.push_back(res_ent(e));
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic idle();
    flush_i = 1'b0; in_valid_i = 1'b0; in_inst_i = '0;
    rs1_i = '0; rs2_i = '0; fv_i = '0; fa_i = '0; fd_i = '0; ordy_i = 1'b0;
  endtask

  task automatic addv(logic fl, logic iv, inst_t w, logic [4:0] r1, logic [4:0] r2,
                      logic [1:0] fv, logic [9:0] fa, logic [63:0] fd, logic ordy, obs_t exp);
    vec_t v;
    v.flush = fl; v.in_valid = iv; v.inst = w; v.rs1 = r1; v.rs2 = r2;
    v.fv = fv; v.fa = fa; v.fd = fd; v.ordy = ordy; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic enq(inst_t w, logic [4:0] r1, logic [4:0] r2, logic ordy);
    idle();
    in_valid_i = 1'b1; in_inst_i = w; rs1_i = r1; rs2_i = r2; ordy_i = ordy;
    step();
    check("enq_model", observe(), model_obs());
  endtask

  initial begin
    inst_t e [5];
    inst_t w2;

    idle();
    // Directed single-cycle vectors
    w2 = mk(12'h0A5, 32'd7, 1'b1, 32'd5, 1'b1, 5'd3);
    addv(0, 1, w2, 0, 0, 2'b00, 0, 0, 1, ob(1, 1, 1, w2));
    addv(0, 0, '0, 0, 0, 2'b00, 0, 0, 1, ob(1, 0, 0, '0));
    addv(0, 1, mk(12'h111, 32'h22, 1, 0, 0, 4), 9, 0, 2'b00, 0, 0, 1, ob(1, 0, 1, '0));
    addv(0, 0, '0, 0, 0, 2'b00, 0, 0, 1, ob(1, 0, 1, '0));
    addv(0, 0, '0, 0, 0, 2'b00, 0, 0, 1, ob(1, 0, 1, '0));
    addv(0, 0, '0, 0, 0, 2'b10, {5'd9, 5'd0}, {32'hDEADBEEF, 32'h0}, 1,
         ob(1, 1, 1, mk(12'h111, 32'h22, 1, 32'hDEADBEEF, 1, 4)));
    addv(0, 0, '0, 0, 0, 2'b00, 0, 0, 1, ob(1, 0, 0, '0));
    addv(0, 1, mk(12'h222, 32'h33, 1, 0, 0, 1), 4, 0, 2'b00, 0, 0, 0, ob(1, 0, 1, '0));
    addv(0, 1, mk(12'h333, 0, 0, 32'h44, 1, 2), 0, 4, 2'b11, {5'd4, 5'd4}, {32'h22, 32'h11}, 0,
         ob(1, 1, 2, mk(12'h222, 32'h33, 1, 32'h11, 1, 1)));
    addv(0, 0, '0, 0, 0, 2'b00, 0, 0, 1, ob(1, 1, 1, mk(12'h333, 32'h11, 1, 32'h44, 1, 2)));
    addv(0, 0, '0, 0, 0, 2'b00, 0, 0, 1, ob(1, 0, 0, '0));
    addv(0, 1, mk(12'h444, 32'h55, 1, 32'hFFFF, 0, 6), 0, 0, 2'b00, 0, 0, 0,
         ob(1, 1, 1, mk(12'h444, 32'h55, 1, 0, 1, 6)));
    addv(0, 0, '0, 0, 0, 2'b00, 0, 0, 1, ob(1, 0, 0, '0));
    addv(0, 1, mk(12'h555, 32'h66, 1, 32'h77, 1, 7), 4, 0, 2'b01, {5'd0, 5'd4}, {32'h0, 32'h99}, 0,
         ob(1, 1, 1, mk(12'h555, 32'h66, 1, 32'h77, 1, 7)));
    addv(0, 0, '0, 0, 0, 2'b00, 0, 0, 1, ob(1, 0, 0, '0));

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("reset", observe(), ob(1, 0, 0, '0));
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      flush_i = vecs[i].flush; in_valid_i = vecs[i].in_valid; in_inst_i = vecs[i].inst;
      rs1_i = vecs[i].rs1; rs2_i = vecs[i].rs2; fv_i = vecs[i].fv; fa_i = vecs[i].fa;
      fd_i = vecs[i].fd; ordy_i = vecs[i].ordy;
      step();
      check($sformatf("vec%0d", i), observe(), vecs[i].exp);
    end

    // Full queue blocked behind an unresolved head, then in-order drain and wrap
    idle();
    flush_i = 1'b1;
    step();
    check("pre_flush", observe(), ob(1, 0, 0, '0));
    e[0] = mk(12'h600, 32'h60, 1, 32'h0, 0, 0);
    for (int k = 1; k < 4; k++)
      e[k] = mk(12'(12'h600 + k), 32'(32'h60 + k), 1, 32'(32'h70 + k), 1, 5'(k));
    e[4] = mk(12'h6AA, 32'h1, 1, 32'h2, 1, 9);
    enq(e[0], 6, 0, 1);
    for (int k = 1; k < 4; k++) enq(e[k], 0, 0, 1);
    check("full_block", observe(), ob(0, 0, 4, '0));
    for (int k = 0; k < 2; k++) begin
      enq(e[4], 0, 0, 1);
      check("full_hold", observe(), ob(0, 0, 4, '0));
    end
    idle();
    ordy_i = 1'b1; fv_i = 2'b01; fa_i = {5'd0, 5'd6}; fd_i = {32'h0, 32'hC0FFEE06};
    step();
    check("head_wake", observe(), ob(0, 1, 4, mk(12'h600, 32'h60, 1, 32'hC0FFEE06, 1, 0)));
    idle();
    ordy_i = 1'b1;
    for (int k = 1; k < 4; k++) begin
      step();
      check($sformatf("drain%0d", k), observe(), ob(1, 1, 4 - k, e[k]));
    end
    step();
    check("drain_empty", observe(), ob(1, 0, 0, '0));
    enq(e[4], 0, 0, 0);
    check("wrap_enq", observe(), ob(1, 1, 1, e[4]));

    // Flush beats enqueue and snoop
    enq(mk(12'h700, 1, 1, 2, 1, 1), 0, 0, 0);
    enq(mk(12'h701, 3, 1, 0, 0, 2), 7, 0, 0);
    idle();
    flush_i = 1'b1; in_valid_i = 1'b1; in_inst_i = mk(12'h702, 5, 1, 0, 0, 3); rs1_i = 7;
    fv_i = 2'b01; fa_i = {5'd0, 5'd7}; fd_i = {32'h0, 32'h77}; ordy_i = 1'b1;
    step();
    check("flush", observe(), ob(1, 0, 0, '0));
    idle();
    ordy_i = 1'b1;
    step();
    check("post_flush", observe(), ob(1, 0, 0, '0));

    // Async reset in the middle of a snoop cycle
    enq(mk(12'h800, 1, 1, 0, 0, 4), 8, 0, 0);
    enq(mk(12'h801, 0, 0, 2, 1, 5), 0, 8, 0);
    idle();
    fv_i = 2'b10; fa_i = {5'd8, 5'd0}; fd_i = {32'h88, 32'h0}; ordy_i = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("async_reset", observe(), ob(1, 0, 0, '0));
    mq.delete();
    @(posedge clk);
    #1;
    check("reset_hold", observe(), ob(1, 0, 0, '0));
    rst_n = 1'b1;
    idle();
    ordy_i = 1'b1;
    step();
    check("no_dispatch", observe(), ob(1, 0, 0, '0));

    // Random traffic against the queue model
    for (int n = 0; n < 3000; n++) begin
      flush_i    = ($urandom_range(0, 40) == 0);
      in_valid_i = $urandom_range(0, 1);
      in_inst_i  = mk(12'($urandom), $urandom, 1'($urandom_range(0, 1)),
                      $urandom, 1'($urandom_range(0, 1)), 5'($urandom));
      rs1_i  = 5'($urandom_range(0, 7));
      rs2_i  = 5'($urandom_range(0, 7));
      fv_i   = 2'($urandom);
      fa_i   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      fd_i   = {$urandom, $urandom};
      ordy_i = ($urandom_range(0, 9) < 7);
      step();
      check("rand", observe(), model_obs());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
